csr_trap_ctrl: RTL and testbench
================================

// Module: csr_trap_ctrl
// PURPOSE
//  Sequencer directly upstream of the CSR register file; drives its single write port and read address.
//  Executes Zicsr ops (CSRRW/RS/RC), ECALL trap entry, MRET and illegal-CSR-write traps.
//  Multi-register updates (mepc, mcause, mstatus) are serialised one write per cycle.
//  Sits in EX; stalls the pipe via ex_ready and redirects fetch via redirect_*.
// PARAMETERS
//  DATA_WIDTH      32  CSR data width
//  CSR_ADDR_WIDTH  12  CSR address width
//  CAUSE_ECALL     11  mcause value for ECALL from M-mode
//  CAUSE_ILLEGAL    2  mcause value for illegal instruction
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   reset: synchronous, active-high
//  ex_valid       in   1   EX carries a valid instruction this cycle
//  ex_ready       out  1   block can accept an instruction (comb: state==IDLE)
//  ex_ecall       in   1   instruction is ECALL
//  ex_mret        in   1   instruction is MRET
//  ex_csr_op      in   2   00 none, 01 RW, 10 RS, 11 RC
//  ex_csr_addr    in   12  target CSR address
//  ex_csr_src     in   32  rs1 value / zero-extended uimm
//  ex_pc          in   32  PC of the EX instruction
//  csr_addr_r     out  12  CSR read address (comb = ex_csr_addr)
//  csr_rdata      in   32  CSR read data for csr_addr_r
//  csr_mtvec      in   32  current mtvec
//  csr_mepc       in   32  current mepc
//  csr_mstatus    in   32  current mstatus
//  csr_we         out  1   CSR write enable (registered)
//  csr_addr_w     out  12  CSR write address (registered)
//  csr_wdata      out  32  CSR write data (registered)
//  csr_rd_valid   out  1   1-cycle pulse: csr_rd_data valid for rd writeback
//  csr_rd_data    out  32  old CSR value for rd
//  redirect_valid out  1   1-cycle pulse: fetch must jump to redirect_pc
//  redirect_pc    out  32  jump target
// BEHAVIOUR
//  Reset: state=IDLE; csr_we, csr_addr_w, csr_wdata, csr_rd_valid, csr_rd_data, redirect_valid, redirect_pc=0; ex_ready=1.
//  Accept when ex_valid && ex_ready. Priority: ecall > mret > csr_op; nothing flagged -> stay IDLE.
//  States: IDLE, CSR_WB, TRAP_EPC, TRAP_CAUSE, TRAP_STATUS, MRET_ST. Every non-IDLE state lasts exactly 1 cycle.
//  CSR op accepted at N: latch old=csr_rdata, new = RW: src | RS: old|src | RC: old&~src.
//   - addr[11:10]==2'b11 (read-only) and write requested -> illegal trap: go to TRAP_EPC with cause CAUSE_ILLEGAL; no rd writeback.
//   - else N+1 = CSR_WB: csr_rd_valid=1, csr_rd_data=old; csr_we=1, addr, new.
//     Exception: RS/RC with src==0 keep csr_we=0. N+2 IDLE.
//  ECALL accepted at N (cause CAUSE_ECALL): pc latched at N.
//   - N+1 TRAP_EPC:    write 0x341 <- pc & ~3.
//   - N+2 TRAP_CAUSE:  write 0x342 <- cause.
//   - N+3 TRAP_STATUS: write 0x300 <- mstatus with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11.
//     Same cycle: redirect_valid=1, redirect_pc = csr_mtvec & ~3 (direct mode only).
//   - N+4 IDLE.
//  MRET accepted at N:
//   - N+1 MRET_ST: write 0x300 <- mstatus with MIE=MPIE, MPIE=1, MPP=2'b11.
//     Same cycle: redirect_valid=1, redirect_pc=csr_mepc.
//   - N+2 IDLE.
//  mstatus/mtvec/mepc are sampled in the cycle their value is used. Prior writes from this block are already committed, so there are no hazards.
//  csr_we/csr_rd_valid/redirect_valid are 0 in any cycle not listed above. ex_* inputs are ignored while ex_ready=0.
//  rst asserted mid-sequence: next edge returns to IDLE with reset output values; the remaining writes are abandoned.
// TESTING
//  CSRRW 0x340 src=0xA5 (old 0): N+1 we=1 addr=0x340 wdata=0xA5, rd_valid=1 rd_data=0; ex_ready low 1 cycle.
//  CSRRS 0x300 src=0 (mstatus=0x1800): rd_data=0x1800, csr_we stays 0; CSRRC src=0x1000 -> wdata=0x0800.
//  ECALL pc=0x104, mstatus=0x1888, mtvec=0x171: writes 0x341=0x104, 0x342=11, 0x300=0x1880 on N+1..N+3.
//   Redirect 0x170 at N+3; ex_ready low 3 cycles.
//  MRET with mepc=0x108, mstatus=0x1880: write 0x300=0x1888; redirect_pc=0x108 at N+1.
//  CSRRW to 0xF14: no rd_valid; trap sequence with mcause=2, mepc=pc. ecall+mret together -> ECALL sequence.
//  rst high at TRAP_CAUSE cycle: next cycle all outputs 0, ex_ready=1, no mstatus write or redirect.

Source files
------------

// File: rtl/csr_trap_ctrl_if.sv
// rtl/csr_trap_ctrl_if.sv - EX-stage instruction handshake into the CSR/trap sequencer
// Purpose: carries one EX instruction (valid/ready plus decoded CSR/trap fields).
// Signals:
//   ex_valid     EX carries a valid instruction this cycle
//   ex_ready     sequencer can accept an instruction
//   ex_ecall     instruction is ECALL
//   ex_mret      instruction is MRET
//   ex_csr_op    00 none, 01 RW, 10 RS, 11 RC
//   ex_csr_addr  target CSR address
//   ex_csr_src   rs1 value / zero-extended uimm
//   ex_pc        PC of the EX instruction
// Modports: master = pipeline side, slave = sequencer side.
interface csr_trap_ctrl_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12
);
    logic                      ex_valid;
    logic                      ex_ready;
    logic                      ex_ecall;
    logic                      ex_mret;
    logic [1:0]                ex_csr_op;
    logic [CSR_ADDR_WIDTH-1:0] ex_csr_addr;
    logic [DATA_WIDTH-1:0]     ex_csr_src;
    logic [DATA_WIDTH-1:0]     ex_pc;

    modport master (
        output ex_valid, ex_ecall, ex_mret, ex_csr_op, ex_csr_addr, ex_csr_src, ex_pc,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_ecall, ex_mret, ex_csr_op, ex_csr_addr, ex_csr_src, ex_pc,
        output ex_ready
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - Zicsr / ECALL / MRET / illegal-write sequencer in front of the CSR file
// Purpose: accepts one EX instruction at a time, serialises its CSR writes one per cycle,
//          returns the old CSR value for rd and redirects fetch on trap entry / MRET.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ex              EX instruction handshake (slave modport)
//   csr_addr_r      CSR read address (follows ex_csr_addr)
//   csr_rdata       read data for csr_addr_r
//   csr_mtvec/mepc/mstatus  current machine CSR values
//   csr_we/csr_addr_w/csr_wdata  registered single write port
//   csr_rd_valid/csr_rd_data     old CSR value for rd writeback (1-cycle pulse)
//   redirect_valid/redirect_pc   fetch redirect (1-cycle pulse)
module csr_trap_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int CAUSE_ECALL    = 11,
    parameter int CAUSE_ILLEGAL  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    csr_trap_ctrl_if.slave            ex,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_r,
    input  logic [DATA_WIDTH-1:0]     csr_rdata,
    input  logic [DATA_WIDTH-1:0]     csr_mtvec,
    input  logic [DATA_WIDTH-1:0]     csr_mepc,
    input  logic [DATA_WIDTH-1:0]     csr_mstatus,
    output logic                      csr_we,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_w,
    output logic [DATA_WIDTH-1:0]     csr_wdata,
    output logic                      csr_rd_valid,
    output logic [DATA_WIDTH-1:0]     csr_rd_data,
    output logic                      redirect_valid,
    output logic [DATA_WIDTH-1:0]     redirect_pc
);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);
    localparam logic [DATA_WIDTH-1:0]     ALIGN_MASK   = ~DATA_WIDTH'(3);

    typedef enum logic [2:0] {
        IDLE, CSR_WB, TRAP_EPC, TRAP_CAUSE, TRAP_STATUS, MRET_ST
    } state_t;

    state_t state_q, state_d;
    logic   cause_illegal_q, cause_illegal_d;

    logic                      we_d, rd_valid_d, redir_valid_d;
    logic [CSR_ADDR_WIDTH-1:0] addr_w_d;
    logic [DATA_WIDTH-1:0]     wdata_d, rd_data_d, redir_pc_d;
    logic [DATA_WIDTH-1:0]     new_val;
    logic                      wr_req;

    assign ex.ex_ready = (state_q == IDLE);
    assign csr_addr_r  = ex.ex_csr_addr;

    // Trap entry: stack MIE into MPIE, disable interrupts, previous mode = M.
    function automatic logic [DATA_WIDTH-1:0] trap_status(input logic [DATA_WIDTH-1:0] m);
        logic [DATA_WIDTH-1:0] s;
        s        = m;
        s[7]     = m[3];
        s[3]     = 1'b0;
        s[12:11] = 2'b11;
        return s;
    endfunction

    // Trap return: restore MIE from MPIE and set MPIE.
    function automatic logic [DATA_WIDTH-1:0] mret_status(input logic [DATA_WIDTH-1:0] m);
        logic [DATA_WIDTH-1:0] s;
        s        = m;
        s[3]     = m[7];
        s[7]     = 1'b1;
        s[12:11] = 2'b11;
        return s;
    endfunction

    always_comb begin
        state_d         = state_q;
        cause_illegal_d = cause_illegal_q;
        we_d            = 1'b0;
        addr_w_d        = '0;
        wdata_d         = '0;
        rd_valid_d      = 1'b0;
        rd_data_d       = '0;
        redir_valid_d   = 1'b0;
        redir_pc_d      = '0;

        unique case (ex.ex_csr_op)
            2'b10:   new_val = csr_rdata | ex.ex_csr_src;
            2'b11:   new_val = csr_rdata & ~ex.ex_csr_src;
            default: new_val = ex.ex_csr_src;
        endcase
        // RS/RC with a zero source are pure reads and must not write.
        wr_req = (ex.ex_csr_op == 2'b01) || (ex.ex_csr_src != '0);

        unique case (state_q)
            IDLE: begin
                if (ex.ex_valid) begin
                    if (ex.ex_ecall ||
                        (ex.ex_csr_op != 2'b00 && !ex.ex_mret && wr_req &&
                         ex.ex_csr_addr[CSR_ADDR_WIDTH-1 -: 2] == 2'b11)) begin
                        // ECALL or write to a read-only CSR: start trap entry with mepc.
                        state_d         = TRAP_EPC;
                        cause_illegal_d = !ex.ex_ecall;
                        we_d            = 1'b1;
                        addr_w_d        = ADDR_MEPC;
                        wdata_d         = ex.ex_pc & ALIGN_MASK;
                    end else if (ex.ex_mret) begin
                        state_d       = MRET_ST;
                        we_d          = 1'b1;
                        addr_w_d      = ADDR_MSTATUS;
                        wdata_d       = mret_status(csr_mstatus);
                        redir_valid_d = 1'b1;
                        redir_pc_d    = csr_mepc;
                    end else if (ex.ex_csr_op != 2'b00) begin
                        state_d    = CSR_WB;
                        rd_valid_d = 1'b1;
                        rd_data_d  = csr_rdata;
                        we_d       = wr_req;
                        addr_w_d   = ex.ex_csr_addr;
                        wdata_d    = new_val;
                    end
                end
            end
            TRAP_EPC: begin
                state_d  = TRAP_CAUSE;
                we_d     = 1'b1;
                addr_w_d = ADDR_MCAUSE;
                wdata_d  = cause_illegal_q ? DATA_WIDTH'(CAUSE_ILLEGAL) : DATA_WIDTH'(CAUSE_ECALL);
            end
            TRAP_CAUSE: begin
                state_d       = TRAP_STATUS;
                we_d          = 1'b1;
                addr_w_d      = ADDR_MSTATUS;
                wdata_d       = trap_status(csr_mstatus);
                redir_valid_d = 1'b1;
                redir_pc_d    = csr_mtvec & ALIGN_MASK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cause_illegal_q <= 1'b0;
            csr_we          <= 1'b0;
            csr_addr_w      <= '0;
            csr_wdata       <= '0;
            csr_rd_valid    <= 1'b0;
            csr_rd_data     <= '0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
        end else begin
            state_q         <= state_d;
            cause_illegal_q <= cause_illegal_d;
            csr_we          <= we_d;
            csr_addr_w      <= addr_w_d;
            csr_wdata       <= wdata_d;
            csr_rd_valid    <= rd_valid_d;
            csr_rd_data     <= rd_data_d;
            redirect_valid  <= redir_valid_d;
            redirect_pc     <= redir_pc_d;
        end
    end
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - randomized self-checking bench for csr_trap_ctrl
module tb_csr_trap_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] csr_addr_r;
    logic [31:0] csr_rdata = '0, csr_mtvec = '0, csr_mepc = '0, csr_mstatus = '0;
    logic        csr_we, csr_rd_valid, redirect_valid;
    logic [11:0] csr_addr_w;
    logic [31:0] csr_wdata, csr_rd_data, redirect_pc;

    int vectors = 0;
    int miscompares = 0;

    csr_trap_ctrl_if bus ();

    csr_trap_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ex             (bus.slave),
        .csr_addr_r     (csr_addr_r),
        .csr_rdata      (csr_rdata),
        .csr_mtvec      (csr_mtvec),
        .csr_mepc       (csr_mepc),
        .csr_mstatus    (csr_mstatus),
        .csr_we         (csr_we),
        .csr_addr_w     (csr_addr_w),
        .csr_wdata      (csr_wdata),
        .csr_rd_valid   (csr_rd_valid),
        .csr_rd_data    (csr_rd_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One expected output cycle after acceptance.
    typedef struct {
        logic        we;
        logic [11:0] aw;
        logic [31:0] wd;
        logic        rv;
        logic [31:0] rd;
        logic        xv;
        logic [31:0] xpc;
    } cyc_t;

    cyc_t exp_q[$];

    function automatic void push(input logic we, input logic [11:0] aw, input logic [31:0] wd,
                                 input logic rv, input logic [31:0] rd,
                                 input logic xv, input logic [31:0] xpc);
        cyc_t c;
        c.we = we; c.aw = aw; c.wd = wd; c.rv = rv; c.rd = rd; c.xv = xv; c.xpc = xpc;
        exp_q.push_back(c);
    endfunction

    function automatic logic [31:0] st_trap(input logic [31:0] m);
        return (m & ~32'h1888) | ((m & 32'h8) << 4) | 32'h1800;
    endfunction

    function automatic logic [31:0] st_mret(input logic [31:0] m);
        return (m & ~32'h1888) | ((m >> 4) & 32'h8) | 32'h80 | 32'h1800;
    endfunction

    // Trap entry: three writes in order, redirect alongside the last.
    function automatic void model_trap(input logic [31:0] cause, input logic [31:0] pc,
                                       input logic [31:0] mtvec, input logic [31:0] mst);
        push(1, 12'h341, pc & ~32'd3, 0, 0, 0, 0);
        push(1, 12'h342, cause, 0, 0, 0, 0);
        push(1, 12'h300, st_trap(mst), 0, 0, 1, mtvec & ~32'd3);
    endfunction

    function automatic void model(input logic ecall, input logic mret, input logic [1:0] op,
                                  input logic [11:0] addr, input logic [31:0] src,
                                  input logic [31:0] pc, input logic [31:0] old,
                                  input logic [31:0] mtvec, input logic [31:0] mepc,
                                  input logic [31:0] mst);
        logic [31:0] nv;
        logic        wr;
        exp_q.delete();
        if (ecall) model_trap(32'd11, pc, mtvec, mst);
        else if (mret) push(1, 12'h300, st_mret(mst), 0, 0, 1, mepc);
        else if (op != 2'b00) begin
            nv = (op == 2'b01) ? src : (op == 2'b10) ? (old | src) : (old & ~src);
            wr = (op == 2'b01) || (src != 0);
            if (wr && addr >= 12'hC00) model_trap(32'd2, pc, mtvec, mst);
            else push(wr, addr, nv, 1, old, 0, 0);
        end
    endfunction

    // Entered at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
    task automatic run_txn(input logic ecall, input logic mret, input logic [1:0] op,
                           input logic [11:0] addr, input logic [31:0] src, input logic [31:0] pc,
                           input logic [31:0] old, input logic [31:0] mtvec,
                           input logic [31:0] mepc, input logic [31:0] mst);
        csr_rdata = old; csr_mtvec = mtvec; csr_mepc = mepc; csr_mstatus = mst;
        bus.ex_valid = 1; bus.ex_ecall = ecall; bus.ex_mret = mret; bus.ex_csr_op = op;
        bus.ex_csr_addr = addr; bus.ex_csr_src = src; bus.ex_pc = pc;
        model(ecall, mret, op, addr, src, pc, old, mtvec, mepc, mst);
        #1 chk("addr_r", {20'd0, csr_addr_r}, {20'd0, addr});
        @(posedge clk);
        foreach (exp_q[i]) begin
            @(negedge clk);
            chk("busy_ready", {31'd0, bus.ex_ready}, 32'd0);
            chk("we", {31'd0, csr_we}, {31'd0, exp_q[i].we});
            if (exp_q[i].we) begin
                chk("addr_w", {20'd0, csr_addr_w}, {20'd0, exp_q[i].aw});
                chk("wdata", csr_wdata, exp_q[i].wd);
            end
            chk("rd_valid", {31'd0, csr_rd_valid}, {31'd0, exp_q[i].rv});
            if (exp_q[i].rv) chk("rd_data", csr_rd_data, exp_q[i].rd);
            chk("redir_valid", {31'd0, redirect_valid}, {31'd0, exp_q[i].xv});
            if (exp_q[i].xv) chk("redir_pc", redirect_pc, exp_q[i].xpc);
            // Garbage on ex_* while busy must be ignored.
            bus.ex_valid = 1'($urandom); bus.ex_ecall = 1'($urandom); bus.ex_mret = 1'($urandom);
            bus.ex_csr_op = 2'($urandom); bus.ex_csr_addr = 12'($urandom);
            bus.ex_csr_src = $urandom; bus.ex_pc = $urandom;
            @(posedge clk);
        end
        if (exp_q.size() == 0) bus.ex_valid = 0;
        @(negedge clk);
        chk("idle_ready", {31'd0, bus.ex_ready}, 32'd1);
        chk("idle_we", {31'd0, csr_we}, 32'd0);
        chk("idle_rv", {31'd0, csr_rd_valid}, 32'd0);
        chk("idle_xv", {31'd0, redirect_valid}, 32'd0);
        bus.ex_valid = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, {31'd0, bus.ex_ready}, 32'd1);
        chk({tag, "_we"}, {31'd0, csr_we}, 32'd0);
        chk({tag, "_addr_w"}, {20'd0, csr_addr_w}, 32'd0);
        chk({tag, "_wdata"}, csr_wdata, 32'd0);
        chk({tag, "_rv"}, {31'd0, csr_rd_valid}, 32'd0);
        chk({tag, "_rd"}, csr_rd_data, 32'd0);
        chk({tag, "_xv"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, "_xpc"}, redirect_pc, 32'd0);
    endtask

    initial begin
        bus.ex_valid = 0; bus.ex_ecall = 0; bus.ex_mret = 0; bus.ex_csr_op = 0;
        bus.ex_csr_addr = 0; bus.ex_csr_src = 0; bus.ex_pc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 0;

        // Directed cases.
        run_txn(0, 0, 2'b01, 12'h340, 32'hA5, 32'h80, 32'h0, 0, 0, 0);
        run_txn(0, 0, 2'b10, 12'h300, 32'h0, 32'h84, 32'h1800, 0, 0, 32'h1800);
        run_txn(0, 0, 2'b11, 12'h300, 32'h1000, 32'h88, 32'h1800, 0, 0, 32'h1800);
        run_txn(1, 0, 2'b00, 12'h000, 32'h0, 32'h104, 32'h0, 32'h171, 0, 32'h1888);
        run_txn(0, 1, 2'b00, 12'h000, 32'h0, 32'h10C, 32'h0, 0, 32'h108, 32'h1880);
        run_txn(0, 0, 2'b01, 12'hF14, 32'h7, 32'h200, 32'h5, 32'h400, 0, 32'h8);
        run_txn(0, 0, 2'b10, 12'hF14, 32'h0, 32'h204, 32'h5, 32'h400, 0, 32'h8);
        run_txn(1, 1, 2'b01, 12'h340, 32'h3, 32'h303, 32'h0, 32'h500, 32'h600, 32'h80);
        run_txn(0, 0, 2'b00, 12'h340, 32'h3, 32'h300, 32'h0, 0, 0, 0);

        // Reset during TRAP_CAUSE abandons the mstatus write and redirect.
        csr_mstatus = 32'h1888; csr_mtvec = 32'h170;
        bus.ex_valid = 1; bus.ex_ecall = 1; bus.ex_mret = 0; bus.ex_csr_op = 0; bus.ex_pc = 32'h400;
        @(posedge clk); @(negedge clk);
        bus.ex_valid = 0;
        chk("rst_seq_epc", {20'd0, csr_addr_w}, 32'h341);
        @(posedge clk); @(negedge clk);
        chk("rst_seq_cause", {20'd0, csr_addr_w}, 32'h342);
        rst = 1;
        @(posedge clk); @(negedge clk);
        check_all_zero("midrst");
        rst = 0;
        @(posedge clk); @(negedge clk);
        check_all_zero("postrst");

        // Randomized transactions.
        for (int n = 0; n < 300; n++) begin
            logic        e, m;
            logic [1:0]  op;
            logic [11:0] a;
            logic [31:0] s;
            e  = ($urandom_range(0, 5) == 0);
            m  = ($urandom_range(0, 4) == 0);
            op = 2'($urandom);
            a  = ($urandom_range(0, 2) == 0) ? (12'hC00 | 12'($urandom)) : 12'($urandom);
            s  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_txn(e, m, op, a, s, $urandom, $urandom, $urandom, $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
